mc_control: RTL and testbench

- Multi-cycle control unit for the RV32I core: FSM sequencing fetch, decode, execute, memory and writeback over a shared ALU.
- Drives PC/IR enables, ALU operation, register-file write and memory request handshakes.
- Stalls on instruction and data memory ready signals and counts retired instructions.
- Flags illegal opcodes and memory timeouts.

---
 rtl/mc_control.sv | 232 +++++++++++++++++++++++
 tb/tb_mc_control.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) over one shared ALU.
// Define MUL_EN to add the MUL instruction and its MULW wait state.
module mc_control #(
  parameter int ALU_CTRL_W   = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            opcode,
  input  logic [2:0]            func3,
  input  logic                  func7_5,
  input  logic                  func7_0,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  mul_done,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  mul_start,
  output logic                  err,
  output logic [CNT_W-1:0]      instret
);

  localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WW-1:0] WLAST = WW'(MEM_WAIT_MAX - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_MULW,
    S_WB,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic [3:0]       alu_code;
  logic [3:0]       alu_op;
  logic             alu_bad;

  logic is_jal, is_jalr, is_br, is_lw;
  logic is_sw, is_opi, is_op, is_mul;
  logic legal, br_ok, br_taken;

  assign is_jal  = (opcode == 5'b11011);
  assign is_jalr = (opcode == 5'b11001);
  assign is_br   = (opcode == 5'b11000);
  assign is_lw   = (opcode == 5'b00000);
  assign is_sw   = (opcode == 5'b01000);
  assign is_opi  = (opcode == 5'b00100);
  assign is_op   = (opcode == 5'b01100);

  assign legal = is_jal | is_jalr | is_br | is_lw |
                 is_sw | is_opi | is_op;

`ifdef MUL_EN
  assign is_mul = is_op & func7_0 & (func3 == 3'b000);
`else
  logic unused_mul;
  assign unused_mul = ^{func7_0, mul_done};
  assign is_mul = 1'b0;
`endif

  // beq/bne/blt/bge all have func3[1] clear; [2] picks SLT, [0] inverts
  assign br_ok    = ~func3[1];
  assign br_taken = (func3[2] ? alu_lt : alu_zero) ^ func3[0];

  always_comb begin
    alu_op  = ALU_ADD;
    alu_bad = 1'b0;
    unique case (func3)
      3'b000: alu_op = (is_op && func7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_bad = 1'b1;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = func7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_src_b = 1'b0;
    alu_code  = ALU_AND;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    mul_start = 1'b0;
    unique case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end else if (wcnt_q == WLAST) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_ID: state_d = legal ? S_EX : S_ERR;
      S_EX: begin
        unique case (1'b1)
          is_op, is_opi: begin
            alu_src_b = is_opi;
            alu_code  = alu_op;
            if (is_mul) begin
              mul_start = 1'b1;
              state_d   = S_MULW;
            end else begin
              state_d = alu_bad ? S_ERR : S_WB;
            end
          end
          is_lw, is_sw: begin
            alu_src_b = 1'b1;
            alu_code  = ALU_ADD;
            state_d   = S_MEM;
          end
          is_br: begin
            alu_code = func3[2] ? ALU_SLT : ALU_SUB;
            pc_src   = 2'b01;
            if (br_ok) begin
              pc_write = br_taken;
              retire   = 1'b1;
              state_d  = S_IF;
            end else begin
              state_d = S_ERR;
            end
          end
          is_jal, is_jalr: begin
            alu_src_b = 1'b1;
            alu_code  = ALU_ADD;
            pc_write  = 1'b1;
            pc_src    = is_jal ? 2'b10 : 2'b11;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            retire    = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = is_sw;
        alu_src_b = 1'b1;
        alu_code  = ALU_ADD;
        if (dmem_ready) begin
          retire  = is_sw;
          state_d = is_sw ? S_IF : S_WB;
        end else if (wcnt_q == WLAST) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
`ifdef MUL_EN
      S_MULW: begin
        if (mul_done) begin
          state_d = S_WB;
        end else if (wcnt_q == WLAST) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
`endif
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_lw ? 2'b01 : (is_mul ? 2'b11 : 2'b00);
        retire    = 1'b1;
        state_d   = S_IF;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign instret_d = instret_q + CNT_W'(retire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      wcnt_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      instret_q <= instret_d;
    end
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_code);
  assign err      = (state_q == S_ERR);
  assign instret  = instret_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream against a per-instruction
// outcome model (cycle count, strobes, ALU op, retirement, error).
module tb_mc_control;

  localparam int CW   = 4;
  localparam int WMAX = 15;
`ifdef MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic       func7_5, func7_0;
  logic       alu_zero, alu_lt;
  logic       imem_ready, dmem_ready, mul_done;
  logic       imem_req, dmem_req, dmem_we;
  logic       ir_write, pc_write, alu_src_b;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] alu_ctrl;
  logic       reg_write, mul_start, err;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  mc_control #(
    .ALU_CTRL_W  (4),
    .MEM_WAIT_MAX(WMAX),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .func3     (func3),
    .func7_5   (func7_5),
    .func7_0   (func7_0),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .mul_done  (mul_done),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src_b (alu_src_b),
    .alu_ctrl  (alu_ctrl),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .mul_start (mul_start),
    .err       (err),
    .instret   (instret)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;
  logic [4:0] optab [0:6];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [2:0] f3,
                                         input logic f75, input bit rtype);
    case (f3)
      3'd0:    alu_ref = (rtype && f75) ? 4'b0110 : 4'b0010;
      3'd1:    alu_ref = 4'b0101;
      3'd2:    alu_ref = 4'b1000;
      3'd4:    alu_ref = 4'b0100;
      3'd5:    alu_ref = f75 ? 4'b1101 : 4'b0111;
      3'd6:    alu_ref = 4'b0001;
      3'd7:    alu_ref = 4'b0000;
      default: alu_ref = 4'b0010;
    endcase
  endfunction

  task automatic do_reset();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    mul_done   = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_outs", 32'({dmem_req, dmem_we, ir_write, pc_write, pc_src,
        alu_src_b, alu_ctrl, reg_write, wb_sel, mul_start}), 32'd0);
    rst = 1'b0;
    exp_ret = 0;
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [2:0] f3,
      input logic f75, input logic f70, input logic z, input logic lt,
      input int iw, input int dw, input int mw);
    bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_mul, legal;
    bit e_err, e_ret, e_dwe, ck_alu, ck_srcb, taken, br_bad;
    int n_if, e_cyc, e_ir, e_dreq, e_ms, e_rw, e_pcw, ex_idx;
    logic [3:0] e_alu;
    logic e_srcb;
    logic [1:0] e_pcsrc, e_wbsel;
    int ireq, dreq, mcnt, c;
    int o_ir, o_dreq, o_ms, o_rw, o_pcw, o_cyc;
    bit o_dwe, fetched, mstart, done, o_err;
    logic [3:0] o_alu;
    logic o_srcb;
    logic [1:0] o_pcsrc, o_wbsel;

    is_r    = (op == 5'b01100);
    is_i    = (op == 5'b00100);
    is_ld   = (op == 5'b00000);
    is_st   = (op == 5'b01000);
    is_br   = (op == 5'b11000);
    is_jal  = (op == 5'b11011);
    is_jalr = (op == 5'b11001);
    is_mul  = MUL && is_r && f70 && (f3 == 3'b000);
    legal   = is_r || is_i || is_ld || is_st || is_br || is_jal || is_jalr;
    n_if = iw + 1;
    ex_idx = n_if + 1;
    e_err = 0; e_ret = 0; e_ir = 1; e_dreq = 0; e_dwe = 0; e_ms = 0;
    e_rw = 0; e_wbsel = 0; e_pcw = 0; e_pcsrc = 0;
    ck_alu = 0; ck_srcb = 0; e_alu = 0; e_srcb = 0; e_cyc = 0;
    taken = 0; br_bad = 0;
    case (f3)
      3'd0: taken = z;
      3'd1: taken = !z;
      3'd4: taken = lt;
      3'd5: taken = !lt;
      default: br_bad = 1;
    endcase
    if (iw >= WMAX) begin
      e_err = 1; e_ir = 0; e_cyc = WMAX;
    end else if (!legal) begin
      e_err = 1; e_cyc = n_if + 1;
    end else if (is_mul) begin
      e_ms = 1;
      if (mw >= WMAX) begin
        e_err = 1; e_cyc = n_if + 2 + WMAX;
      end else begin
        e_cyc = n_if + 4 + mw; e_rw = 1; e_wbsel = 3; e_ret = 1;
      end
    end else if (is_r || is_i) begin
      ck_srcb = 1; e_srcb = is_i;
      if (f3 == 3'b011) begin
        e_err = 1; e_cyc = n_if + 2;
      end else begin
        ck_alu = 1; e_alu = alu_ref(f3, f75, is_r);
        e_rw = 1; e_ret = 1; e_cyc = n_if + 3;
      end
    end else if (is_ld || is_st) begin
      ck_alu = 1; e_alu = 4'b0010; ck_srcb = 1; e_srcb = 1; e_dwe = is_st;
      if (dw >= WMAX) begin
        e_err = 1; e_dreq = WMAX; e_cyc = n_if + 2 + WMAX;
      end else begin
        e_dreq = dw + 1; e_ret = 1;
        e_cyc = n_if + 3 + dw + (is_ld ? 1 : 0);
        if (is_ld) begin e_rw = 1; e_wbsel = 1; end
      end
    end else if (is_br) begin
      ck_srcb = 1; e_srcb = 0;
      if (br_bad) begin
        e_err = 1; e_cyc = n_if + 2;
      end else begin
        ck_alu = 1; e_alu = f3[2] ? 4'b1000 : 4'b0110;
        e_pcw = int'(taken); e_pcsrc = 1; e_ret = 1; e_cyc = n_if + 2;
      end
    end else begin
      ck_alu = 1; e_alu = 4'b0010; e_pcw = 1;
      e_pcsrc = is_jal ? 2'd2 : 2'd3;
      e_rw = 1; e_wbsel = 2; e_ret = 1; e_cyc = n_if + 2;
    end

    ireq = 0; dreq = 0; mcnt = 0; c = 0;
    o_ir = 0; o_dreq = 0; o_ms = 0; o_rw = 0; o_pcw = 0; o_cyc = -1;
    o_dwe = 0; fetched = 0; mstart = 0; done = 0; o_err = 0;
    o_alu = 0; o_srcb = 0; o_pcsrc = 0; o_wbsel = 0;
    while (!done && c < 100) begin
      if (fetched) begin
        opcode = op; func3 = f3; func7_5 = f75; func7_0 = f70;
      end else begin
        opcode = 5'($urandom); func3 = 3'($urandom);
        func7_5 = 1'($urandom); func7_0 = 1'($urandom);
      end
      alu_zero = z;
      alu_lt = lt;
      imem_ready = imem_req ? (ireq >= iw) : 1'($urandom);
      dmem_ready = dmem_req ? (dreq >= dw) : 1'($urandom);
      mul_done = mstart ? (mcnt >= mw) : 1'($urandom);
      #1;
      if (err) begin
        o_err = 1; done = 1; o_cyc = c;
        chk("err_outs", 32'({imem_req, dmem_req, dmem_we, ir_write,
            pc_write, pc_src, alu_src_b, alu_ctrl, reg_write, wb_sel,
            mul_start}), 32'd0);
      end else if (fetched && imem_req) begin
        done = 1; o_cyc = c;
      end else begin
        if (ir_write) begin
          o_ir++;
          chk("fetch_pc", 32'({pc_write, pc_src}), 32'b100);
        end else if (pc_write) begin
          o_pcw++; o_pcsrc = pc_src;
        end
        if (c == ex_idx) begin o_alu = alu_ctrl; o_srcb = alu_src_b; end
        if (reg_write) begin o_rw++; o_wbsel = wb_sel; end
        if (dmem_req) begin o_dreq++; o_dwe = dmem_we; end
        if (mul_start) o_ms++;
        if (mstart) mcnt++;
        if (mul_start) mstart = 1;
        if (imem_req) ireq++;
        if (dmem_req) dreq++;
        if (ir_write) fetched = 1;
        c++;
        @(negedge clk);
      end
    end

    chk("done", 32'(done), 32'd1);
    chk("cycles", 32'(o_cyc), 32'(e_cyc));
    chk("err", 32'(o_err), 32'(e_err));
    chk("ir_write", 32'(o_ir), 32'(e_ir));
    if (ck_alu) chk("alu_ctrl", 32'(o_alu), 32'(e_alu));
    if (ck_srcb) chk("alu_src_b", 32'(o_srcb), 32'(e_srcb));
    chk("pc_write", 32'(o_pcw), 32'(e_pcw));
    if (e_pcw != 0) chk("pc_src", 32'(o_pcsrc), 32'(e_pcsrc));
    chk("reg_write", 32'(o_rw), 32'(e_rw));
    if (e_rw != 0) chk("wb_sel", 32'(o_wbsel), 32'(e_wbsel));
    chk("dmem_req", 32'(o_dreq), 32'(e_dreq));
    if (e_dreq != 0) chk("dmem_we", 32'(o_dwe), 32'(e_dwe));
    chk("mul_start", 32'(o_ms), 32'(e_ms));
    if (e_ret) exp_ret = (exp_ret + 1) % (1 << CW);
    chk("instret", 32'(instret), 32'(exp_ret));
    if (o_err) do_reset();
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(13, 16));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    optab[0] = 5'b11011; optab[1] = 5'b11001; optab[2] = 5'b11000;
    optab[3] = 5'b00000; optab[4] = 5'b01000; optab[5] = 5'b00100;
    optab[6] = 5'b01100;
    rst = 1'b1;
    opcode = 0; func3 = 0; func7_5 = 0; func7_0 = 0;
    alu_zero = 0; alu_lt = 0;
    imem_ready = 0; dmem_ready = 0; mul_done = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // add, lw with slow data memory, bne taken / not taken
    run_instr(5'b01100, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    run_instr(5'b00000, 3'b010, 0, 0, 0, 0, 0, 3, 0);
    run_instr(5'b11000, 3'b001, 0, 0, 0, 0, 0, 0, 0);
    run_instr(5'b11000, 3'b001, 0, 0, 1, 0, 0, 0, 0);
    run_instr(5'b11000, 3'b100, 0, 0, 0, 1, 1, 0, 0);
    run_instr(5'b11011, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    run_instr(5'b11001, 3'b000, 0, 0, 0, 0, 2, 0, 0);
    run_instr(5'b01000, 3'b010, 0, 0, 0, 0, 0, 14, 0);
    run_instr(5'b01100, 3'b101, 1, 0, 0, 0, 14, 0, 0);
    // fetch timeout, illegal opcode, sltu, bad branch, load timeout
    run_instr(5'b01100, 3'b000, 0, 0, 0, 0, 20, 0, 0);
    run_instr(5'b11111, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    run_instr(5'b01100, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    run_instr(5'b11000, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    run_instr(5'b00000, 3'b010, 0, 0, 0, 0, 0, 15, 0);
    // mul (plain add when MUL_EN is off), then a mul timeout
    run_instr(5'b01100, 3'b000, 0, 1, 0, 0, 0, 0, 2);
    run_instr(5'b01100, 3'b000, 0, 1, 0, 0, 0, 0, 15);

    do_reset();
    for (int k = 0; k < 16; k++)
      run_instr(5'b01100, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    chk("instret_wrap", 32'(instret), 32'd0);

    // reset while a load waits in MEM
    run_instr(5'b00100, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    opcode = 5'b00000; func3 = 3'b010; func7_5 = 0; func7_0 = 0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mem_hold", 32'(dmem_req), 32'd1);
    do_reset();

    for (int k = 0; k < 200; k++) begin
      int r;
      logic [4:0] op;
      r = int'($urandom_range(0, 7));
      op = (r == 7) ? 5'($urandom) : optab[r];
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom),
                pick_wait(), pick_wait(), pick_wait());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
